// File: rtl/camera_target_stabilizer_if.sv
// Frame-in / target-out bundle between the camera decoder, the stabilizer and the arm controller.
// Ports: in_valid/in_x/in_y/in_wh/in_angle (decoded frame), tgt_valid/tgt_ready/tgt_* (target handshake),
//        match_cnt (consecutive-match count), stale (tracking-timeout pulse).
interface camera_target_stabilizer_if;
   logic        in_valid;
   logic [8:0]  in_x;
   logic [7:0]  in_y;
   logic [3:0]  in_wh;
   logic [11:0] in_angle;
   logic        tgt_valid;
   logic        tgt_ready;
   logic [8:0]  tgt_x;
   logic [7:0]  tgt_y;
   logic [3:0]  tgt_wh;
   logic [11:0] tgt_angle;
   logic [3:0]  match_cnt;
   logic        stale;

   // driver side: frame source and target consumer
   modport master (
      output in_valid, in_x, in_y, in_wh, in_angle, tgt_ready,
      input  tgt_valid, tgt_x, tgt_y, tgt_wh, tgt_angle, match_cnt, stale
   );

   // stabilizer side
   modport slave (
      input  in_valid, in_x, in_y, in_wh, in_angle, tgt_ready,
      output tgt_valid, tgt_x, tgt_y, tgt_wh, tgt_angle, match_cnt, stale
   );
endinterface

// File: rtl/camera_target_stabilizer.sv
// Debounces decoded camera frames: a target is issued after STABLE_CNT consecutive frames agree
// within tolerance and held on tgt_valid/tgt_ready. Latency: target valid the cycle after the final frame.
// Ports: Clk, rst_n (async, active-low), clear (sync flush), bus (slave modport). Optional TGT_AVG_EN averages the target.
module camera_target_stabilizer #(
   parameter int STABLE_CNT  = 4,
   parameter int POS_TOL     = 4,
   parameter int ANGLE_TOL   = 22,
   parameter int TIMEOUT_CYC = 50_000_000
) (
   input  logic Clk,
   input  logic rst_n,
   input  logic clear,
   camera_target_stabilizer_if.slave bus
);

   localparam logic [3:0] STABLE = 4'(STABLE_CNT);
   localparam int         TW     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   generate
      if (STABLE_CNT < 2 || STABLE_CNT > 15) begin : g_bad_cnt
         $error("STABLE_CNT must be within 2..15");
      end
`ifdef TGT_AVG_EN
      if (STABLE_CNT != 2 && STABLE_CNT != 4 && STABLE_CNT != 8) begin : g_bad_avg
         $error("TGT_AVG_EN requires STABLE_CNT of 2, 4 or 8");
      end
`endif
   endgenerate

   typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

   state_t        state, next_state;
   logic [8:0]    ref_x;
   logic [7:0]    ref_y;
   logic [3:0]    ref_wh;
   logic [11:0]   ref_angle;
   logic [TW-1:0] timer;

   logic load_ref, bump, issue, drop, timeout;
   logic [9:0]  dx;
   logic [8:0]  dy;
   logic [12:0] dang;
   logic        match;
   logic [3:0]  cnt_inc;

   // Absolute differences taken as larger-minus-smaller so no sign handling is needed.
   assign dx   = (bus.in_x >= ref_x) ? 10'(bus.in_x) - 10'(ref_x) : 10'(ref_x) - 10'(bus.in_x);
   assign dy   = (bus.in_y >= ref_y) ? 9'(bus.in_y) - 9'(ref_y) : 9'(ref_y) - 9'(bus.in_y);
   assign dang = (bus.in_angle >= ref_angle) ? 13'(bus.in_angle) - 13'(ref_angle)
                                             : 13'(ref_angle) - 13'(bus.in_angle);
   assign match = (bus.in_wh == ref_wh) && (dx <= 10'(POS_TOL)) &&
                  (dy <= 9'(POS_TOL)) && (dang <= 13'(ANGLE_TOL));
   assign cnt_inc = bus.match_cnt + 4'd1;

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // drop = return to IDLE with the count zeroed (clear, wh=0 frame, timeout, handshake)
   always_comb begin
      next_state = state;
      load_ref   = 1'b0;
      bump       = 1'b0;
      issue      = 1'b0;
      drop       = 1'b0;
      timeout    = 1'b0;
      if (clear) begin
         next_state = IDLE;
         drop       = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && bus.in_wh != 4'd0) begin
                  load_ref   = 1'b1;
                  next_state = TRACK;
               end
            end
            TRACK: begin
               if (bus.in_valid) begin
                  if (bus.in_wh == 4'd0) begin
                     drop       = 1'b1;
                     next_state = IDLE;
                  end else if (match) begin
                     bump = 1'b1;
                     if (cnt_inc == STABLE) begin
                        issue      = 1'b1;
                        next_state = HOLD;
                     end
                  end else begin
                     load_ref = 1'b1;
                  end
               end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
                  timeout    = 1'b1;
                  drop       = 1'b1;
                  next_state = IDLE;
               end
            end
            HOLD: begin
               if (bus.tgt_valid && bus.tgt_ready) begin
                  drop       = 1'b1;
                  next_state = IDLE;
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   // Target value: either the completing frame itself or the truncated mean of the accepted frames.
   logic [8:0]  out_x;
   logic [7:0]  out_y;
   logic [11:0] out_angle;
`ifdef TGT_AVG_EN
   localparam int SH = $clog2(STABLE_CNT);
   logic [12:0] sum_x, sum_x_nx;
   logic [11:0] sum_y, sum_y_nx;
   logic [15:0] sum_a, sum_a_nx;

   assign sum_x_nx  = sum_x + 13'(bus.in_x);
   assign sum_y_nx  = sum_y + 12'(bus.in_y);
   assign sum_a_nx  = sum_a + 16'(bus.in_angle);
   assign out_x     = sum_x_nx[SH +: 9];
   assign out_y     = sum_y_nx[SH +: 8];
   assign out_angle = sum_a_nx[SH +: 12];

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_x <= '0;
         sum_y <= '0;
         sum_a <= '0;
      end else if (load_ref) begin
         sum_x <= 13'(bus.in_x);
         sum_y <= 12'(bus.in_y);
         sum_a <= 16'(bus.in_angle);
      end else if (bump) begin
         sum_x <= sum_x_nx;
         sum_y <= sum_y_nx;
         sum_a <= sum_a_nx;
      end
   end
`else
   assign out_x     = bus.in_x;
   assign out_y     = bus.in_y;
   assign out_angle = bus.in_angle;
`endif

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_x         <= '0;
         ref_y         <= '0;
         ref_wh        <= '0;
         ref_angle     <= '0;
         timer         <= '0;
         bus.match_cnt <= '0;
         bus.tgt_valid <= 1'b0;
         bus.tgt_x     <= '0;
         bus.tgt_y     <= '0;
         bus.tgt_wh    <= '0;
         bus.tgt_angle <= '0;
         bus.stale     <= 1'b0;
      end else begin
         bus.stale <= timeout;

         // Idle timer only runs while tracking; any frame restarts it.
         if (state != TRACK || bus.in_valid || clear) timer <= '0;
         else                                         timer <= timer + TW'(1);

         if (drop)          bus.match_cnt <= '0;
         else if (load_ref) bus.match_cnt <= 4'd1;
         else if (bump)     bus.match_cnt <= cnt_inc;

         if (load_ref) begin
            ref_x     <= bus.in_x;
            ref_y     <= bus.in_y;
            ref_wh    <= bus.in_wh;
            ref_angle <= bus.in_angle;
         end

         // tgt_valid is high exactly while in HOLD; the only exits from HOLD assert drop.
         bus.tgt_valid <= issue | (bus.tgt_valid & ~drop);
         if (issue) begin
            bus.tgt_x     <= out_x;
            bus.tgt_y     <= out_y;
            bus.tgt_wh    <= ref_wh;
            bus.tgt_angle <= out_angle;
         end
      end
   end

endmodule

// File: tb/tb_camera_target_stabilizer.sv
// Directed bench for camera_target_stabilizer: STABLE_CNT=4, TIMEOUT_CYC=100.
// Expected values are hand-computed; the TGT_AVG_EN build expects averaged targets.
module tb_camera_target_stabilizer;
   logic Clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   int   total = 0;
   int   bad = 0;

   camera_target_stabilizer_if bus();

   camera_target_stabilizer #(
      .STABLE_CNT(4), .POS_TOL(4), .ANGLE_TOL(22), .TIMEOUT_CYC(100)
   ) dut (
      .Clk(Clk), .rst_n(rst_n), .clear(clear), .bus(bus)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Drives one frame for exactly one cycle; returns 1 time unit after the sampling edge.
   task automatic frame(input logic [8:0] x, input logic [7:0] y, input logic [3:0] wh,
                        input logic [11:0] a);
      bus.in_valid = 1'b1;
      bus.in_x     = x;
      bus.in_y     = y;
      bus.in_wh    = wh;
      bus.in_angle = a;
      @(posedge Clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge Clk); #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_vld"}, 32'(bus.tgt_valid), 0);
      chk({tag, "_x"},   32'(bus.tgt_x), 0);
      chk({tag, "_y"},   32'(bus.tgt_y), 0);
      chk({tag, "_wh"},  32'(bus.tgt_wh), 0);
      chk({tag, "_ang"}, 32'(bus.tgt_angle), 0);
      chk({tag, "_cnt"}, 32'(bus.match_cnt), 0);
      chk({tag, "_stale"}, 32'(bus.stale), 0);
   endtask

   initial begin
      logic early;
      int   exp_x, exp_a;
      bus.in_valid = 0; bus.in_x = 0; bus.in_y = 0; bus.in_wh = 0; bus.in_angle = 0;
      bus.tgt_ready = 1'b1;
      repeat (3) @(posedge Clk);
      #1;
      chk_all_zero("rst");
      rst_n = 1'b1;
      tick();

      // four identical frames
      for (int i = 1; i <= 4; i++) begin
         frame(9'd200, 8'd100, 4'd3, 12'd330);
         chk($sformatf("ident_cnt%0d", i), 32'(bus.match_cnt), 32'(i));
      end
      chk("ident_vld", 32'(bus.tgt_valid), 1);
      chk("ident_x", 32'(bus.tgt_x), 200);
      chk("ident_y", 32'(bus.tgt_y), 100);
      chk("ident_wh", 32'(bus.tgt_wh), 3);
      chk("ident_ang", 32'(bus.tgt_angle), 330);
      tick();
      chk("ident_vld_drop", 32'(bus.tgt_valid), 0);
      chk("ident_cnt_after", 32'(bus.match_cnt), 0);

      // jitter within tolerance
`ifdef TGT_AVG_EN
      exp_x = 201; exp_a = 335;
`else
      exp_x = 204; exp_a = 352;
`endif
      frame(9'd200, 8'd100, 4'd3, 12'd330);
      frame(9'd203, 8'd100, 4'd3, 12'd350);
      frame(9'd197, 8'd100, 4'd3, 12'd310);
      frame(9'd204, 8'd100, 4'd3, 12'd352);
      chk("jit_vld", 32'(bus.tgt_valid), 1);
      chk("jit_x", 32'(bus.tgt_x), 32'(exp_x));
      chk("jit_ang", 32'(bus.tgt_angle), 32'(exp_a));
      tick();

      // out-of-tolerance frame restarts the count
      frame(9'd200, 8'd100, 4'd3, 12'd330);
      frame(9'd200, 8'd100, 4'd3, 12'd330);
      frame(9'd210, 8'd100, 4'd3, 12'd330);
      chk("restart_cnt", 32'(bus.match_cnt), 1);
      frame(9'd210, 8'd100, 4'd3, 12'd330);
      frame(9'd210, 8'd100, 4'd3, 12'd330);
      chk("restart_no_tgt", 32'(bus.tgt_valid), 0);
      frame(9'd210, 8'd100, 4'd3, 12'd330);
      chk("restart_vld", 32'(bus.tgt_valid), 1);
      chk("restart_x", 32'(bus.tgt_x), 210);
      tick();

      // backpressure: target held, extra frames ignored
      bus.tgt_ready = 1'b0;
      for (int i = 0; i < 4; i++) frame(9'd50, 8'd60, 4'd5, 12'd100);
      for (int i = 0; i < 5; i++) frame(9'(300 + i * 20), 8'(i * 30), 4'd7, 12'(i * 500));
      repeat (1000) @(posedge Clk);
      #1;
      chk("bp_vld", 32'(bus.tgt_valid), 1);
      chk("bp_x", 32'(bus.tgt_x), 50);
      chk("bp_y", 32'(bus.tgt_y), 60);
      chk("bp_wh", 32'(bus.tgt_wh), 5);
      chk("bp_ang", 32'(bus.tgt_angle), 100);
      chk("bp_cnt", 32'(bus.match_cnt), 4);
      bus.tgt_ready = 1'b1;
      tick();
      chk("bp_release_vld", 32'(bus.tgt_valid), 0);
      chk("bp_release_cnt", 32'(bus.match_cnt), 0);
      frame(9'd50, 8'd60, 4'd5, 12'd100);
      chk("bp_idle_cnt", 32'(bus.match_cnt), 1);

      // wh=0 after two matches
      frame(9'd50, 8'd60, 4'd5, 12'd100);
      chk("wh0_pre", 32'(bus.match_cnt), 2);
      frame(9'd50, 8'd60, 4'd0, 12'd100);
      chk("wh0_cnt", 32'(bus.match_cnt), 0);

      // timeout after silence
      frame(9'd10, 8'd10, 4'd2, 12'd0);
      frame(9'd10, 8'd10, 4'd2, 12'd0);
      early = 1'b0;
      for (int i = 1; i < 100; i++) begin
         tick();
         if (bus.stale) early = 1'b1;
      end
      chk("to_early", 32'(early), 0);
      chk("to_cnt_before", 32'(bus.match_cnt), 2);
      tick();
      chk("to_stale", 32'(bus.stale), 1);
      chk("to_cnt", 32'(bus.match_cnt), 0);
      tick();
      chk("to_stale_width", 32'(bus.stale), 0);

      // clear together with handshake
      for (int i = 0; i < 4; i++) frame(9'd77, 8'd33, 4'd9, 12'd800);
      chk("clr_hs_vld_pre", 32'(bus.tgt_valid), 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_hs_vld", 32'(bus.tgt_valid), 0);
      chk("clr_hs_cnt", 32'(bus.match_cnt), 0);
      chk("clr_hs_keep_x", 32'(bus.tgt_x), 77);
      repeat (5) tick();
      chk("clr_hs_no_tgt", 32'(bus.tgt_valid), 0);

      // clear beats a same-cycle completing frame
      for (int i = 0; i < 3; i++) frame(9'd77, 8'd33, 4'd9, 12'd800);
      clear = 1'b1;
      frame(9'd77, 8'd33, 4'd9, 12'd800);
      clear = 1'b0;
      chk("clr_frame_vld", 32'(bus.tgt_valid), 0);
      chk("clr_frame_cnt", 32'(bus.match_cnt), 0);
      frame(9'd77, 8'd33, 4'd9, 12'd800);
      chk("clr_then_cnt", 32'(bus.match_cnt), 1);

      // asynchronous reset mid-track
      frame(9'd77, 8'd33, 4'd9, 12'd800);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("arst");
      tick();
      rst_n = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/camera_target_stabilizer.md
# camera_target_stabilizer

Debounces decoded camera frames before they reach the arm motion controller. It takes the single-cycle frame strobe and fields from the UART camera decoder: X, Y, warehouse number and scaled angle. A target is issued only after STABLE_CNT consecutive frames agree within tolerance. The accepted target is held on a valid/ready handshake until the arm controller takes it.

## Interface
- STABLE_CNT, 4, matching frames required before a target is issued; legal range 2..15
- POS_TOL, 4, max |ΔX| and |ΔY| in pixels for a frame to count as matching
- ANGLE_TOL, 22, max |Δangle| in scaled angle units
- TIMEOUT_CYC, 50_000_000, idle cycles without a frame before tracking is abandoned
- Clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush; highest priority
- in_valid  in  1  one-cycle frame strobe from the decoder
- in_x  in  9  frame X
- in_y  in  8  frame Y
- in_wh  in  4  warehouse number; 0 = no object
- in_angle  in  12  scaled angle
- tgt_valid  out  1  target available
- tgt_ready  in  1  consumer accepts target
- tgt_x  out  9  target X
- tgt_y  out  8  target Y
- tgt_wh  out  4  target warehouse
- tgt_angle  out  12  target angle
- match_cnt  out  4  current consecutive-match count
- stale  out  1  one-cycle pulse on tracking timeout

## Operation
- States: IDLE (no reference), TRACK (reference held, counting), HOLD (target presented).
- A frame matches when all of the following hold:
  - in_wh == ref_wh;
  - |in_x−ref_x| ≤ POS_TOL, computed as an 10-bit unsigned difference;
  - |in_y−ref_y| ≤ POS_TOL, computed as a 9-bit unsigned difference;
  - |in_angle−ref_angle| ≤ ANGLE_TOL, computed as a 13-bit unsigned difference.
- Angle is linear; there is no wrap-around.
- IDLE, in_valid with in_wh≠0:
  - ref ← frame, match_cnt ← 1;
  - go to TRACK.
- TRACK, in_valid with in_wh==0: go to IDLE, match_cnt ← 0.
- TRACK, matching frame:
  - match_cnt increments; ref is unchanged.
  - If the new count equals STABLE_CNT: tgt_* ← output value (see Configuration), tgt_valid ← 1, go to HOLD.
- TRACK, non-matching frame (in_wh≠0): ref ← frame, match_cnt ← 1, stay in TRACK.
- TRACK timeout: after TIMEOUT_CYC consecutive cycles without in_valid:
  - go to IDLE, match_cnt ← 0;
  - stale pulses high for 1 cycle.
- Timeout counter: cleared on every in_valid and on state entry; not run in IDLE or HOLD.
- HOLD:
  - in_valid frames are dropped; they have no effect on state, count or ref.
  - tgt_* remain stable while tgt_valid=1.
  - When tgt_valid && tgt_ready at a rising edge: tgt_valid ← 0, match_cnt ← 0, go to IDLE.
- clear: go to IDLE, tgt_valid ← 0, match_cnt ← 0, timeout counter ← 0; tgt_* data is kept.
  - clear wins over a same-cycle in_valid, handshake or timeout.
- Timeout and in_valid in the same cycle: the frame is processed; no timeout.

## Timing
- Reset values: all outputs 0 (tgt_valid, tgt_x/y/wh/angle, match_cnt, stale); state IDLE.
- Frame-to-target latency: tgt_valid is high in the cycle after the in_valid that completes the STABLE_CNT-th match.
- Back-to-back in_valid on consecutive cycles is supported; each frame is evaluated against the ref as updated at the previous edge.
- tgt_ready may be held high permanently.
  - Minimum tgt_valid high time is 1 cycle.
  - The earliest next target is STABLE_CNT frames after the handshake.
- A reset mid-HOLD drops the pending target; tgt_valid is low asynchronously.
- stale is registered, exactly 1 cycle wide.

## Configuration
- TGT_AVG_EN defined:
  - Per-field running sums of accepted frames are kept. Widths: X 13b, Y 12b, angle 16b.
  - The sums are reloaded with the frame on each ref load.
  - On issue, tgt_x/y/angle = sum / STABLE_CNT, truncated.
  - STABLE_CNT must be 2, 4 or 8; the division is a right shift, checked at elaboration.
- TGT_AVG_EN undefined: tgt_x/y/angle = the last matching frame; no sum registers exist.
- tgt_wh = ref_wh in both builds.

## Test plan
- Four identical frames (x=200, y=100, wh=3, angle=330), STABLE_CNT=4, tgt_ready=1:
  - tgt_valid pulses 1 cycle after the 4th strobe with 200/100/3/330;
  - match_cnt reads 1,2,3,4 then 0.
- Jitter frames x=200,203,197,204, angle=330,350,310,352:
  - target issued; x=204/angle=352, or 201/335 with TGT_AVG_EN.
- Frames x=200,200,210,210,210,210:
  - 3rd frame restarts the count at 1; target after the 6th frame with x=210.
- Backpressure: tgt_ready=0 for 1000 cycles, 5 extra distinct frames sent:
  - tgt_* unchanged and tgt_valid held;
  - after ready, state IDLE and match_cnt=0.
- Timeout: TIMEOUT_CYC=100, two frames then silence:
  - stale pulses exactly 100 cycles after the 2nd strobe; match_cnt→0.
- wh=0 after 2 matches → match_cnt=0.
- clear asserted in the same cycle as a handshake → IDLE, no further target.
- rst_n low mid-TRACK → all outputs 0.
